// File: rtl/piano_pkg.sv
// Shared definitions for the piano key/tone path.
package piano_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  // 10 ms hold time at CLK_HZ
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500_000;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StPlay,
    StDrain
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// Single-bit button conditioner: 2-FF synchronizer followed by a hold-time debouncer.
module key_debounce
  import piano_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_i,
  output logic key_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             key_s_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synced input disagrees with the accepted level.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (key_s_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = key_s_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer, counter and accepted-level registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q   <= 1'b0;
      key_s_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= key_i;
      key_s_q  <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign key_o = stable_q;

endmodule

// File: rtl/note_key_mux.sv
// Debounces the note keys, picks the lowest-index pressed key and routes its tone to the
// speaker, switching only while the outgoing tone is low so no truncated pulse is emitted.
module note_key_mux
  import piano_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 19,
  parameter int unsigned IDX_W           = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [NUM_KEYS-1:0] tone_in,
  output logic                audio_out,
  output logic [NUM_KEYS-1:0] keys_db,
  output logic [IDX_W-1:0]    active_key,
  output logic                key_valid
);

  logic [NUM_KEYS-1:0] tone_meta_q;
  logic [NUM_KEYS-1:0] tone_s_q;
  logic                req_valid;
  logic [IDX_W-1:0]    req_idx;
  logic                tone_cur;
  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic                audio_q, audio_d;

  for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk_i  (clk),
      .reset_i(reset),
      .key_i  (key_in[i]),
      .key_o  (keys_db[i])
    );
  end

  assign req_valid = |keys_db;
  assign tone_cur  = tone_s_q[cur_q];

  // Fixed priority: lowest set bit of the debounced keys wins.
  always_comb begin
    req_idx = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (keys_db[i]) begin
        req_idx = IDX_W'(i);
      end
    end
  end

  // Tone synchronizers plus FSM state, current key and speaker registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tone_meta_q <= '0;
      tone_s_q    <= '0;
      state_q     <= StIdle;
      cur_q       <= '0;
      audio_q     <= 1'b0;
    end else begin
      tone_meta_q <= tone_in;
      tone_s_q    <= tone_meta_q;
      state_q     <= state_d;
      cur_q       <= cur_d;
      audio_q     <= audio_d;
    end
  end

  // Next state: arm waits for a low tone so playback starts on a rising half-period,
  // drain waits for the tone to fall before letting go of the speaker.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid) state_d = StArm;
      end
      StArm: begin
        if (!req_valid) begin
          state_d = StIdle;
        end else if (req_idx == cur_q && !tone_cur) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (!req_valid || req_idx != cur_q) state_d = StDrain;
      end
      StDrain: begin
        if (!tone_cur) state_d = req_valid ? StArm : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs: speaker level and the key being tracked.
  always_comb begin
    audio_d = 1'b0;
    cur_d   = cur_q;
    case (state_q)
      StIdle: begin
        if (req_valid) cur_d = req_idx;
      end
      StArm: begin
        if (req_valid && req_idx != cur_q) cur_d = req_idx;
      end
      StPlay: begin
        audio_d = tone_cur;
      end
      StDrain: begin
        audio_d = tone_cur;
        // Request is only re-sampled once the drain completes
        if (!tone_cur && req_valid) cur_d = req_idx;
      end
      default: ;
    endcase
  end

  assign audio_out  = audio_q;
  assign active_key = cur_q;
  assign key_valid  = (state_q == StPlay) || (state_q == StDrain);

endmodule

// File: tb/tb_note_key_mux.sv
// Directed bench for note_key_mux with a cycle-level reference model.
module tb_note_key_mux;

  localparam int NK  = 8;
  localparam int DEB = 4;

  localparam int PhIdle  = 0;
  localparam int PhArm   = 1;
  localparam int PhPlay  = 2;
  localparam int PhDrain = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] tone_in = '0;
  logic          audio_out;
  logic [NK-1:0] keys_db;
  logic [2:0]    active_key;
  logic          key_valid;

  note_key_mux #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .IDX_W          (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .tone_in   (tone_in),
    .audio_out (audio_out),
    .keys_db   (keys_db),
    .active_key(active_key),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int unsigned cyc = 0;
  int per[NK] = '{20, 18, 12, 14, 10, 16, 22, 24};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Free-running square waves, tone i has period per[i] clocks.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      for (int i = 0; i < NK; i++) tone_in[i] = ((cyc % per[i]) < (per[i] / 2));
    end
  end

  // Reference model: inputs seen two clocks late, a key is accepted after DEB consecutive
  // disagreeing samples, and the speaker selection follows the idle/arm/play/drain rules.
  logic [NK-1:0] m_key_d1, m_key_d2, m_tone_d1, m_tone_d2, m_db;
  int m_disagree[NK];
  int m_phase;
  int m_cur;
  bit m_audio;

  function automatic int lowest(input logic [NK-1:0] v);
    for (int i = 0; i < NK; i++) if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_key_d1 = '0; m_key_d2 = '0; m_tone_d1 = '0; m_tone_d2 = '0; m_db = '0;
        for (int i = 0; i < NK; i++) m_disagree[i] = 0;
        m_phase = PhIdle; m_cur = 0; m_audio = 0;
      end else begin
        bit any;
        int req;
        bit t;
        any = |m_db;
        req = lowest(m_db);
        t   = m_tone_d2[m_cur];
        case (m_phase)
          PhIdle: begin
            m_audio = 0;
            if (any) begin m_cur = req; m_phase = PhArm; end
          end
          PhArm: begin
            m_audio = 0;
            if (!any) m_phase = PhIdle;
            else if (req != m_cur) m_cur = req;
            else if (!t) m_phase = PhPlay;
          end
          PhPlay: begin
            m_audio = t;
            if (!any || req != m_cur) m_phase = PhDrain;
          end
          default: begin
            m_audio = t;
            if (!t) begin
              if (any) begin m_cur = req; m_phase = PhArm; end
              else m_phase = PhIdle;
            end
          end
        endcase
        for (int i = 0; i < NK; i++) begin
          if (m_key_d2[i] == m_db[i]) begin
            m_disagree[i] = 0;
          end else begin
            m_disagree[i]++;
            if (m_disagree[i] == DEB) begin
              m_db[i] = m_key_d2[i];
              m_disagree[i] = 0;
            end
          end
        end
        m_key_d2 = m_key_d1; m_key_d1 = key_in;
        m_tone_d2 = m_tone_d1; m_tone_d1 = tone_in;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("m_audio", audio_out, m_audio);
        check("m_keys_db", keys_db, m_db);
        check("m_active_key", active_key, m_cur);
        check("m_key_valid", key_valid, (m_phase == PhPlay) || (m_phase == PhDrain));
      end
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!key_valid && n < 300) begin tick(1); n++; end
    check("wait_valid", key_valid, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((key_valid || keys_db != 0 || audio_out) && n < 300) begin tick(1); n++; end
    check("idle_valid", key_valid, 0);
    check("idle_audio", audio_out, 0);
  endtask

  initial begin
    reset = 1'b1;
    tick(3);
    chk_en = 1;
    check("rst0_audio", audio_out, 0);
    check("rst0_keys_db", keys_db, 0);
    check("rst0_active", active_key, 0);
    check("rst0_valid", key_valid, 0);
    reset = 1'b0;

    // Debounce: two short bounces, then a hold; accepted on the 6th edge after the last rise
    key_in[0] = 1'b1; tick(2);
    key_in[0] = 1'b0; tick(2);
    key_in[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check("db_rise", keys_db[0], (k == 6) ? 1 : 0);
    end
    tick(60);
    key_in[0] = 1'b0;
    wait_idle();

    // Start alignment on key 3 pressed while its tone is high
    begin
      int n = 0;
      while (!tone_in[3] && n < 20) begin tick(1); n++; end
    end
    key_in[3] = 1'b1;
    wait_valid();
    check("start_key", active_key, 3);
    check("start_audio", audio_out, 0);

    // Priority switch to key 0 while key 3 is held
    tick(20);
    key_in[0] = 1'b1;
    begin
      int n = 0;
      while (!(key_valid && active_key == 0) && n < 300) begin tick(1); n++; end
    end
    check("prio_key", active_key, 0);
    check("prio_valid", key_valid, 1);

    // Release everything mid-high-phase
    tick(30);
    begin
      int n = 0;
      while (!audio_out && n < 40) begin tick(1); n++; end
    end
    key_in = '0;
    wait_idle();

    // Simultaneous press of keys 5 and 2
    key_in = 8'h24;
    wait_valid();
    check("simul_key", active_key, 2);
    tick(60);
    check("simul_hold", active_key, 2);
    key_in = '0;
    wait_idle();

    // Reset while playing key 3
    key_in[3] = 1'b1;
    wait_valid();
    tick(5);
    check("pre_rst_valid", key_valid, 1);
    reset = 1'b1;
    tick(1);
    check("rst_audio", audio_out, 0);
    check("rst_valid", key_valid, 0);
    check("rst_keys_db", keys_db, 0);
    check("rst_active", active_key, 0);
    reset = 1'b0;
    key_in = '0;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_key_mux.md
Name: note_key_mux

Overview:
- Downstream of the per-note square-wave generators.
- Takes NUM_KEYS raw push-button inputs and the NUM_KEYS tone waveforms produced by the note generators, then debounces the keys and picks one key by fixed priority.
- Drives a single speaker pin with the selected tone.
- Switches tones only while the outgoing waveform is low, so the speaker never sees a truncated half-period glitch.

Parameters:
- NUM_KEYS, 8, number of keys/tones. Index 0 is C4 and has the highest priority.
- DEBOUNCE_CYCLES, 500000, number of clk cycles an input must hold a new level before it is accepted (10 ms at 50 MHz).
- CNT_W, 19, width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- IDX_W, 3, width of the key index. Equals clog2(NUM_KEYS).

Ports:
- clk, input, 1, system clock (50 MHz).
- reset, input, 1, synchronous, active-high reset.
- key_in, input, NUM_KEYS, raw asynchronous buttons, 1 = pressed.
- tone_in, input, NUM_KEYS, square waves from the note generators. Bit i is the tone for key i.
- audio_out, output, 1, speaker drive (Puerto A pin).
- keys_db, output, NUM_KEYS, debounced key state.
- active_key, output, IDX_W, index of the key currently sounding.
- key_valid, output, 1, high while the FSM is in PLAY or DRAIN.

Behaviour:
- Reset, synchronous and active-high. At the next clk edge:
  - audio_out=0, keys_db=0, active_key=0, key_valid=0.
  - All synchronizer flops and debounce counters are cleared.
  - The FSM goes to IDLE.
  - Reset asserted mid-note silences the output on that edge, with no drain.
- Synchronizers: key_in and tone_in each pass through a 2-FF synchronizer. The synchronized signals are key_s and tone_s.
- Debounce, per bit i:
  - If key_s[i]==keys_db[i], the counter is cleared to 0.
  - Otherwise the counter increments. When counter==DEBOUNCE_CYCLES-1, keys_db[i]<=key_s[i] and the counter is cleared.
  - Result: a clean input change appears on keys_db 2+DEBOUNCE_CYCLES edges after it appears on key_in.
  - A bounce shorter than DEBOUNCE_CYCLES restarts the count and never propagates.
- Request: req_valid = |keys_db. req_idx = lowest set bit of keys_db. Both are combinational.
- FSM states: IDLE, ARM, PLAY, DRAIN.
  - IDLE: audio_out<=0. If req_valid, cur<=req_idx and go to ARM.
  - ARM:
    - audio_out<=0.
    - If !req_valid, go to IDLE.
    - Else if req_idx!=cur, cur<=req_idx and stay in ARM.
    - Else if tone_s[cur]==0, go to PLAY. This guarantees the note starts on a rising half-period.
  - PLAY: audio_out<=tone_s[cur]. If !req_valid or req_idx!=cur, go to DRAIN.
  - DRAIN:
    - audio_out<=tone_s[cur].
    - When tone_s[cur]==0: audio_out<=0. Then go to ARM with cur<=req_idx if req_valid, else go to IDLE.
    - The new request is re-evaluated at DRAIN exit. Keys pressed or released during DRAIN do not extend or abort the drain.
- active_key = cur, registered. key_valid = (state==PLAY || state==DRAIN).
- Latency: audio_out follows tone_in with 3 clk of latency (2 sync + 1 output register).
- Simultaneous presses: the lowest index wins. Releasing the winner while others are held causes DRAIN, then ARM on the next-lowest held key.
- A tone stuck high holds DRAIN indefinitely. This is accepted: the generators free-run by design.

Decomposition:
- Shared package piano_pkg holds:
  - the FSM state typedef (IDLE/ARM/PLAY/DRAIN);
  - CLK_HZ=50000000;
  - DEBOUNCE_CYCLES default.
- One sub-module, key_debounce: a single bit with 2-FF sync, counter, and stable output. It is instantiated NUM_KEYS times via generate.
- The tone synchronizers stay inline.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4 in sim and tone_in driven as free-running squares, period 20 clk for key 0 and 14 clk for key 3.
1. Reset: assert reset during PLAY on key 3 -> next edge audio_out=0, key_valid=0, keys_db=0, active_key=0, and the FSM is in IDLE.
2. Debounce: key_in[0] toggles 1,0,1 with 2-cycle bounces, then holds 1 -> keys_db[0] rises exactly 6 edges after the final rise and never pulses earlier.
3. Start alignment: press key 3 while tone_in[3] is high -> audio_out stays 0 until tone_s[3] falls. Its first rise then matches tone_in[3] delayed 3 clk, and key_valid=1 with active_key=3.
4. Priority switch: hold key 3, then press key 0 -> audio_out finishes key 3's current high phase (DRAIN), goes 0, re-arms, and then follows tone 0 with active_key=0.
5. Release: release all keys mid-high-phase -> audio_out stays high until the phase ends, then 0, with key_valid=0 and the FSM in IDLE. No pulse shorter than the half-period is ever produced.
6. Simultaneous press of keys 5 and 2 on the same cycle -> active_key=2, and key 5 is never heard while key 2 is held.
